// File: rtl/seq_det_prog.sv
// seq_det_prog: programmable serial sequence detector.
// Shifts qualified serial bits into a history register, compares the newest
// len_r bits against a runtime pattern, pulses seq_out one cycle after the
// completing bit and keeps a saturating count of detections.
module seq_det_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 16,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'('b1101),
    parameter int                 RST_LEN     = 4,
    parameter bit                 RST_OVERLAP = 1'b1,
    parameter int                 LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               seq_valid,
    input  logic               seq_in,
    input  logic               cnt_clr,
    output logic               seq_out,
    output logic [CNT_W-1:0]   det_cnt
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] pat_r;
    logic [LEN_W-1:0]   len_r;
    logic               ovl_r;
    logic [LEN_W-1:0]   fill;

    logic [MAX_LEN-1:0] nhist;
    logic [LEN_W-1:0]   nfill;
    logic [LEN_W-1:0]   len_clamp;
    logic               pat_eq;
    logic               match;

    // Saturating increment: the count sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Next history/fill and match decision for the bit presented this cycle.
    always_comb begin
        nhist     = {hist[MAX_LEN-2:0], seq_in};
        nfill     = (fill >= MAX_LEN_L) ? fill : fill + 1'b1;
        len_clamp = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
        pat_eq    = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            // Only the newest len_r bits take part; higher pattern bits are don't-care.
            if ((LEN_W'(i) < len_r) && (nhist[i] != pat_r[i])) begin
                pat_eq = 1'b0;
            end
        end
        // A configuration write discards the bit of that cycle.
        match = seq_valid && !cfg_we && (len_r != '0) && (nfill >= len_r) && pat_eq;
    end

    // Configuration registers and shift history; a write flushes the history so
    // no match can straddle old and new configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_r <= RST_PATTERN;
            len_r <= LEN_W'(RST_LEN);
            ovl_r <= RST_OVERLAP;
            hist  <= '0;
            fill  <= '0;
        end else if (cfg_we) begin
            pat_r <= cfg_pattern;
            len_r <= len_clamp;
            ovl_r <= cfg_overlap;
            hist  <= '0;
            fill  <= '0;
        end else if (seq_valid) begin
            hist <= nhist;
            // Non-overlapping mode restarts the fill so the next match needs fresh bits.
            fill <= (match && !ovl_r) ? '0 : nfill;
        end
    end

    // Registered match pulse and saturating detection counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_out <= 1'b0;
            det_cnt <= '0;
        end else begin
            seq_out <= match;
            if (cnt_clr) begin
                det_cnt <= match ? CNT_W'(1) : '0;
            end else if (match) begin
                det_cnt <= sat_inc(det_cnt);
            end
        end
    end

endmodule

// File: tb/tb_seq_det_prog.sv
// Bench for seq_det_prog: table of directed vectors on a default-width
// instance, then hand-written gap/random/saturation sequences.
module tb_seq_det_prog;

    logic       clk = 1'b0;
    logic       rst, cfg_we, cfg_overlap, seq_valid, seq_in, cnt_clr;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       seq_out_a, seq_out_b;
    logic [15:0] det_cnt_a;
    logic [2:0]  det_cnt_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_det_prog #(.MAX_LEN(8), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .seq_valid(seq_valid),
        .seq_in(seq_in), .cnt_clr(cnt_clr), .seq_out(seq_out_a), .det_cnt(det_cnt_a)
    );

    seq_det_prog #(.MAX_LEN(8), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .seq_valid(seq_valid),
        .seq_in(seq_in), .cnt_clr(cnt_clr), .seq_out(seq_out_b), .det_cnt(det_cnt_b)
    );

    typedef struct {
        logic       rst;
        logic       we;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl;
        logic       v;
        logic       in;
        logic       clr;
        logic       eo;
        int         ec;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic we, input logic [7:0] pat,
                       input logic [3:0] len, input logic ovl, input logic v,
                       input logic in, input logic clr, input logic eo, input int ec);
        vec_t t;
        t.rst = r; t.we = we; t.pat = pat; t.len = len; t.ovl = ovl;
        t.v = v; t.in = in; t.clr = clr; t.eo = eo; t.ec = ec;
        tbl.push_back(t);
    endtask

    // Drive inputs on the falling edge, then return 1 time unit after the rising edge.
    task automatic drive(input logic r, input logic we, input logic [7:0] pat,
                         input logic [3:0] len, input logic ovl, input logic v,
                         input logic in, input logic clr);
        @(negedge clk);
        rst = r; cfg_we = we; cfg_pattern = pat; cfg_len = len;
        cfg_overlap = ovl; seq_valid = v; seq_in = in; cnt_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic bit_in(input logic v, input logic in);
        drive(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, v, in, 1'b0);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    initial begin
        logic bits[7];
        int   gaps[7];
        int   exp_cnt;
        logic tog;

        rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        seq_valid = 1'b0; seq_in = 1'b0; cnt_clr = 1'b0;

        // Reset to defaults: 1101, length 4, overlap.
        add(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        // Overlapping stream 1,1,0,1,1,0,1: pulses after bits 4 and 7.
        add(0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1, 1, 0, 1, 1);
        add(0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 1);
        add(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 8'h00, 0, 0, 1, 1, 0, 1, 2);
        // Non-overlapping 1101: single pulse after bit 4.
        add(0, 1, 8'h0D, 4, 0, 0, 0, 0, 0, 2);
        add(0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 2);
        add(0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 2);
        add(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 2);
        add(0, 0, 8'h00, 0, 0, 1, 1, 0, 1, 3);
        add(0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 3);
        add(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 3);
        add(0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 3);
        // Config write flushes history; seq_in=1 in the write cycle is dropped.
        add(0, 1, 8'h0D, 4, 1, 0, 0, 0, 0, 3);
        add(0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 3);
        add(0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 3);
        add(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 3);
        add(0, 1, 8'h03, 2, 1, 1, 1, 0, 0, 3);
        add(0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 3);
        add(0, 0, 8'h00, 0, 0, 1, 1, 0, 1, 4);
        add(0, 0, 8'h00, 0, 0, 1, 1, 0, 1, 5);
        // Clear together with a match loads 1; clear alone loads 0.
        add(0, 0, 8'h00, 0, 0, 1, 1, 1, 1, 1);
        add(0, 0, 8'h00, 0, 0, 0, 1, 1, 0, 0);
        // Length 9 clamps to 8; pattern A5 matches only after all 8 bits.
        add(0, 1, 8'hA5, 9, 1, 0, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1, 1, 0, 1, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].we, tbl[i].pat, tbl[i].len, tbl[i].ovl,
                  tbl[i].v, tbl[i].in, tbl[i].clr);
            check("tbl_seq_out", i, 32'(seq_out_a), 32'(tbl[i].eo));
            check("tbl_det_cnt", i, 32'(det_cnt_a), 32'(tbl[i].ec));
        end

        // Length 0 disables detection: random bits never pulse.
        drive(0, 1, 8'hA5, 4'd0, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            bit_in(1'b1, 1'($urandom_range(0, 1)));
            check("len0_seq_out", i, 32'(seq_out_a), 32'd0);
            check("len0_det_cnt", i, 32'(det_cnt_a), 32'd1);
        end

        // Valid gaps with seq_in toggling: same pulses, one cycle after each completing bit.
        drive(0, 1, 8'h0D, 4'd4, 1, 0, 0, 0);
        bits = '{1, 1, 0, 1, 1, 0, 1};
        gaps = '{1, 2, 3, 1, 2, 3, 1};
        exp_cnt = 1;
        tog = 1'b0;
        for (int k = 0; k < 7; k++) begin
            bit_in(1'b1, bits[k]);
            if (k == 3 || k == 6) exp_cnt++;
            check("gap_bit_out", k, 32'(seq_out_a), (k == 3 || k == 6) ? 32'd1 : 32'd0);
            check("gap_bit_cnt", k, 32'(det_cnt_a), 32'(exp_cnt));
            for (int g = 0; g < gaps[k]; g++) begin
                tog = ~tog;
                bit_in(1'b0, tog);
                check("gap_idle_out", k, 32'(seq_out_a), 32'd0);
                check("gap_idle_cnt", k, 32'(det_cnt_a), 32'(exp_cnt));
            end
        end

        // 3-bit counter: saturation, clear with match, mid-stream reset.
        drive(1, 0, 8'h00, 4'd0, 0, 0, 0, 0);
        check("sat_rst_cnt", 0, 32'(det_cnt_b), 32'd0);
        drive(0, 1, 8'h01, 4'd1, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            bit_in(1'b1, 1'b1);
            check("sat_out", i, 32'(seq_out_b), 32'd1);
            check("sat_cnt", i, 32'(det_cnt_b), (i < 7) ? 32'(i + 1) : 32'd7);
        end
        drive(0, 0, 8'h00, 4'd0, 0, 1, 1, 1);
        check("clr_match_cnt", 0, 32'(det_cnt_b), 32'd1);
        bit_in(1'b1, 1'b1);
        check("post_clr_cnt", 0, 32'(det_cnt_b), 32'd2);
        drive(1, 0, 8'h00, 4'd0, 0, 1, 1, 0);
        check("rst_mid_out", 0, 32'(seq_out_b), 32'd0);
        check("rst_mid_cnt", 0, 32'(det_cnt_b), 32'd0);
        // Config reverted to 1101/4: a lone 1 no longer matches, 1101 does.
        bits[0] = 1; bits[1] = 1; bits[2] = 0; bits[3] = 1;
        for (int k = 0; k < 4; k++) begin
            bit_in(1'b1, bits[k]);
            check("revert_out", k, 32'(seq_out_b), (k == 3) ? 32'd1 : 32'd0);
            check("revert_cnt", k, 32'(det_cnt_b), (k == 3) ? 32'd1 : 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_det_prog.md
# seq_det_prog

Programmable serial sequence detector. It is the parametrised successor to the fixed-pattern `seq` detector, and sits in the same position: it samples a one-bit serial stream and pulses on each occurrence of a target pattern. Pattern, length and overlap mode are runtime-configurable up to `MAX_LEN` bits. Input is qualified by a valid strobe, and the block keeps a saturating detection counter.

## Interface
Parameters:
- `MAX_LEN`, 8: maximum pattern length in bits, at least 2.
- `CNT_W`, 16: width of the detection counter.
- `RST_PATTERN`, `'b1101`: pattern loaded at reset. Width is `MAX_LEN`.
- `RST_LEN`, 4: pattern length loaded at reset.
- `RST_OVERLAP`, 1: overlap mode loaded at reset.
- `LEN_W`, `$clog2(MAX_LEN+1)`: width of the length field. Derived; do not override.

Ports:
- `clk` in 1: the single clock. All logic is on its rising edge.
- `rst` in 1: reset. Synchronous, active-high.
- `cfg_we` in 1: single-cycle write strobe for the configuration.
- `cfg_pattern` in `MAX_LEN`: pattern. Bit `[len-1]` is the first bit received; bit `[0]` is the last.
- `cfg_len` in `LEN_W`: pattern length.
  - 0 disables detection.
  - Values above `MAX_LEN` are clamped to `MAX_LEN`.
- `cfg_overlap` in 1: overlap mode. 1 = overlapping matches allowed; 0 = non-overlapping.
- `seq_valid` in 1: `seq_in` is sampled only when this is 1.
- `seq_in` in 1: serial data bit.
- `cnt_clr` in 1: synchronous clear of `det_cnt`.
- `seq_out` out 1: one-cycle match pulse. Registered.
- `det_cnt` out `CNT_W`: number of matches. Saturating.

## Operation
Internal state:
- `hist`: `MAX_LEN`-bit shift history.
- `fill`: count of valid bits accepted, 0..`MAX_LEN`, saturating.
- `pat_r`, `len_r`, `ovl_r`: configuration registers.

Reset (`rst`=1 at a clock edge):
- `hist`=0, `fill`=0, `seq_out`=0, `det_cnt`=0.
- `pat_r`=`RST_PATTERN`, `len_r`=`RST_LEN`, `ovl_r`=`RST_OVERLAP`.
- Reset has priority over every other input.

Accepting a bit (`seq_valid`=1, `cfg_we`=0):
- `nhist` = {`hist[MAX_LEN-2:0]`, `seq_in`}.
- `nfill` = min(`fill`+1, `MAX_LEN`).
- `match` = (`len_r`≠0) and (`nfill` ≥ `len_r`) and (`nhist[len_r-1:0]` == `pat_r[len_r-1:0]`).
- `hist` <= `nhist`.
- `fill` <= 0 if (`match` and `ovl_r`=0); otherwise `nfill`.

Cycles with `seq_valid`=0:
- `hist` and `fill` hold.
- `match`=0.

Pattern storage:
- Pattern bits above `len_r-1` are don't-care.

Configuration write (`cfg_we`=1):
- `pat_r` <= `cfg_pattern`.
- `len_r` <= min(`cfg_len`, `MAX_LEN`).
- `ovl_r` <= `cfg_overlap`.
- `hist` <= 0 and `fill` <= 0.
- `seq_in` in that cycle is discarded and `match`=0.
- `det_cnt` is unaffected.
- A match can never span bits from both sides of a configuration write.

Counter update:
- If `cnt_clr`=1: `det_cnt` <= (`match` ? 1 : 0).
- Else if `match`=1 and `det_cnt` is not all-ones: `det_cnt` <= `det_cnt`+1.
- Otherwise `det_cnt` holds.
- `det_cnt` saturates at 2^`CNT_W`−1 and never wraps.

Output:
- `seq_out` <= `match` on every clock.

## Timing
- Latency: a bit that completes a match is sampled at edge N. `seq_out`=1 and the incremented `det_cnt` are visible after edge N, for exactly one cycle in the case of `seq_out`.
- Throughput: one bit per clock. Back-to-back matches give consecutive `seq_out` pulses. Example: pattern `11`, length 2, overlap, stream 1,1,1.
- A configuration written at edge N applies to the first bit sampled at edge N+1.
- `rst` asserted mid-stream: `seq_out` is 0 after that edge, even if a match would have completed.

## Test plan
1. Reset defaults (`1101`, length 4, overlap). Stream 1,1,0,1,1,0,1 with `seq_valid` held at 1 -> `seq_out` pulses after bits 4 and 7; `det_cnt`=2.
2. Same stream after writing `cfg_overlap`=0, pattern `1101`, length 4 -> a single pulse after bit 4; `det_cnt` increments by 1.
3. Scenario 1 stream with `seq_valid`=0 gaps of 1–3 cycles between bits, and `seq_in` toggling during the gaps -> identical pulse pattern; each pulse lands one cycle after its completing valid bit.
4. Feed 1,1,0. Then write pattern `'b11`, length 2, overlap 1 with `seq_in`=1 in the write cycle. Then feed 1,1,1 -> no pulse from pre-write history; pulses after post-write bits 2 and 3.
5. Two edge cases:
   - `cfg_len`=0, then 20 random bits -> no pulse, `det_cnt` unchanged.
   - `cfg_len`=9 with `MAX_LEN`=8, pattern `8'hA5`, stream 1,0,1,0,0,1,0,1 -> one pulse after bit 8.
6. `CNT_W`=3, pattern `'b1`, length 1, overlap:
   - 9 valid 1-bits -> `det_cnt` saturates at 7.
   - Then `cnt_clr` together with a matching bit -> `det_cnt`=1.
   - Then `rst` mid-stream -> all outputs 0; configuration reverts to `RST_*`.
